// File: rtl/reg_bus_slave_regfile.sv
// REG_BUS responder terminating one splitter port: local register file with
// ID, scratch, control, W1C event status + interrupt mask, a 64-bit
// free-running counter with atomic snapshot read, and user control words.
module reg_bus_slave_regfile #(
   parameter logic [31:0] ID_VALUE  = 32'h5245_4731,
   parameter int unsigned NUM_EVT   = 8,
   parameter int unsigned NUM_UCTRL = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      WREN,
   input  logic [31:0]               WADR,
   input  logic [31:0]               WDAT,
   input  logic                      RDEN,
   input  logic [31:0]               RADR,
   output logic [31:0]               RDAT,
   output logic                      RVLD,
   input  logic [NUM_EVT-1:0]        evt_i,
   output logic                      irq_o,
   output logic [32*NUM_UCTRL-1:0]   uctrl_o
);

   // Word indices (byte offset >> 2)
   localparam logic [5:0] IDX_ID      = 6'h00;
   localparam logic [5:0] IDX_SCRATCH = 6'h01;
   localparam logic [5:0] IDX_CTRL    = 6'h02;
   localparam logic [5:0] IDX_STATUS  = 6'h03;
   localparam logic [5:0] IDX_MASK    = 6'h04;
   localparam logic [5:0] IDX_CNT_LO  = 6'h05;
   localparam logic [5:0] IDX_CNT_HI  = 6'h06;
   localparam logic [5:0] IDX_UCTRL0  = 6'h08;

   logic [5:0]                    widx;
   logic [5:0]                    ridx;
   logic [31:0]                   scratch_q;
   logic                          cnt_en_q;
   logic [NUM_EVT-1:0]            status_q;
   logic [NUM_EVT-1:0]            mask_q;
   logic [63:0]                   cnt_q;
   logic [31:0]                   shadow_q;
   logic [NUM_UCTRL-1:0][31:0]    uctrl_q;
   logic                          wr_ctrl;
   logic                          cnt_clr;
   logic [NUM_EVT-1:0]            w1c_bits;
   logic [31:0]                   rd_data;

   assign widx     = WADR[7:2];
   assign ridx     = RADR[7:2];
   assign wr_ctrl  = WREN && (widx == IDX_CTRL);
   assign cnt_clr  = wr_ctrl && WDAT[1];
   assign w1c_bits = (WREN && (widx == IDX_STATUS)) ? WDAT[NUM_EVT-1:0] : '0;
   assign uctrl_o  = uctrl_q;

   // Plain RW registers: scratch, counter enable, irq mask, user control words
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scratch_q <= '0;
         cnt_en_q  <= 1'b0;
         mask_q    <= '0;
         uctrl_q   <= '0;
      end else if (WREN) begin
         if (widx == IDX_SCRATCH) scratch_q <= WDAT;
         if (widx == IDX_CTRL)    cnt_en_q  <= WDAT[0];
         if (widx == IDX_MASK)    mask_q    <= WDAT[NUM_EVT-1:0];
         for (int unsigned k = 0; k < NUM_UCTRL; k++) begin
            if (widx == 6'(IDX_UCTRL0 + k)) uctrl_q[k] <= WDAT;
         end
      end
   end

   // Sticky event status: a new event wins over a same-cycle W1C
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) status_q <= '0;
      else     status_q <= (status_q & ~w1c_bits) | evt_i;
   end

   // Registered interrupt from masked status
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) irq_o <= 1'b0;
      else     irq_o <= |(status_q & mask_q);
   end

   // Free-running counter; clear-on-write has priority over increment
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)           cnt_q <= '0;
      else if (cnt_clr)  cnt_q <= '0;
      else if (cnt_en_q) cnt_q <= cnt_q + 64'd1;
   end

   // Upper counter half captured by the same CNT_LO read that samples the lower half
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                              shadow_q <= '0;
      else if (RDEN && (ridx == IDX_CNT_LO)) shadow_q <= cnt_q[63:32];
   end

   // Read mux over pre-edge register state, so a same-cycle write is not seen
   always_comb begin
      rd_data = 32'hDEAD_BEEF;
      case (ridx)
         IDX_ID:      rd_data = ID_VALUE;
         IDX_SCRATCH: rd_data = scratch_q;
         IDX_CTRL:    rd_data = {31'd0, cnt_en_q};
         IDX_STATUS: begin
            rd_data = '0;
            rd_data[NUM_EVT-1:0] = status_q;
         end
         IDX_MASK: begin
            rd_data = '0;
            rd_data[NUM_EVT-1:0] = mask_q;
         end
         IDX_CNT_LO:  rd_data = cnt_q[31:0];
         IDX_CNT_HI:  rd_data = shadow_q;
         default: begin
            for (int unsigned k = 0; k < NUM_UCTRL; k++) begin
               if (ridx == 6'(IDX_UCTRL0 + k)) rd_data = uctrl_q[k];
            end
         end
      endcase
   end

   // One-cycle read response; RDAT holds between reads
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         RVLD <= 1'b0;
         RDAT <= '0;
      end else begin
         RVLD <= RDEN;
         if (RDEN) RDAT <= rd_data;
      end
   end

endmodule

// File: tb/tb_reg_bus_slave_regfile.sv
// Directed self-checking bench for reg_bus_slave_regfile.
module tb_reg_bus_slave_regfile;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          WREN = 1'b0;
   logic [31:0]   WADR = '0;
   logic [31:0]   WDAT = '0;
   logic          RDEN = 1'b0;
   logic [31:0]   RADR = '0;
   logic [31:0]   RDAT;
   logic          RVLD;
   logic [7:0]    evt_i = '0;
   logic          irq_o;
   logic [127:0]  uctrl_o;

   int checks   = 0;
   int failures = 0;

   reg_bus_slave_regfile #(
      .ID_VALUE (32'h5245_4731),
      .NUM_EVT  (8),
      .NUM_UCTRL(4)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .WREN   (WREN),
      .WADR   (WADR),
      .WDAT   (WDAT),
      .RDEN   (RDEN),
      .RADR   (RADR),
      .RDAT   (RDAT),
      .RVLD   (RVLD),
      .evt_i  (evt_i),
      .irq_o  (irq_o),
      .uctrl_o(uctrl_o)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      WADR = a; WDAT = d; WREN = 1'b1;
      @(posedge CLK); #1;
      WREN = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      RADR = a; RDEN = 1'b1;
      @(posedge CLK); #1;
      RDEN = 1'b0;
      chk({tag, "_vld"}, 32'(RVLD), 32'd1);
      chk(tag, RDAT, exp);
   endtask

   initial begin
      #3 RST = 1'b1;
      #1;
      chk("rst_rdat", RDAT, 32'h0);
      chk("rst_rvld", 32'(RVLD), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_uctrl", uctrl_o[31:0] | uctrl_o[63:32] | uctrl_o[95:64] | uctrl_o[127:96], 32'h0);
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(posedge CLK); #1;

      // ID, unmapped, aliasing, RVLD pulse and RDAT hold
      rd("id", 32'h0000_0000, 32'h5245_4731);
      chk("rvld_pulse", 32'(RVLD), 32'd1);
      @(posedge CLK); #1;
      chk("rvld_drop", 32'(RVLD), 32'd0);
      chk("rdat_hold", RDAT, 32'h5245_4731);
      rd("unmapped_1c", 32'h0000_001C, 32'hDEAD_BEEF);
      rd("unmapped_30", 32'h0000_0030, 32'hDEAD_BEEF);
      rd("alias_id", 32'h0000_0100, 32'h5245_4731);

      // Scratch and same-cycle read/write ordering
      wr(32'h04, 32'hA5A5_0F0F);
      RADR = 32'h04; RDEN = 1'b1;
      WADR = 32'h04; WDAT = 32'h1234_5678; WREN = 1'b1;
      @(posedge CLK); #1;
      WREN = 1'b0;
      // back-to-back read: RDEN stays high for a second cycle
      chk("rw_same_vld", 32'(RVLD), 32'd1);
      chk("rw_same_old", RDAT, 32'hA5A5_0F0F);
      @(posedge CLK); #1;
      RDEN = 1'b0;
      chk("b2b_vld", 32'(RVLD), 32'd1);
      chk("scratch_new", RDAT, 32'h1234_5678);
      wr(32'h44, 32'h0);   // 0x44 is unmapped; must not disturb anything
      rd("scratch_keep", 32'h04, 32'h1234_5678);

      // Events, mask, W1C
      evt_i = 8'h08;
      @(posedge CLK); #1;
      evt_i = 8'h00;
      rd("status_set", 32'h0C, 32'h08);
      chk("irq_masked", 32'(irq_o), 32'd0);
      wr(32'h10, 32'h0000_0108);
      chk("irq_lag", 32'(irq_o), 32'd0);
      @(posedge CLK); #1;
      chk("irq_on", 32'(irq_o), 32'd1);
      rd("mask_rb", 32'h10, 32'h08);
      evt_i = 8'h08;
      wr(32'h0C, 32'h08);
      evt_i = 8'h00;
      rd("status_setwins", 32'h0C, 32'h08);
      wr(32'h0C, 32'h08);
      chk("irq_lag_clr", 32'(irq_o), 32'd1);
      rd("status_clr", 32'h0C, 32'h00);
      chk("irq_off", 32'(irq_o), 32'd0);

      // Counter: 100 enabled edges after clear
      wr(32'h08, 32'h3);
      repeat (100) @(posedge CLK);
      #1;
      rd("cnt_lo_100", 32'h14, 32'd100);
      rd("cnt_hi_0", 32'h18, 32'h0);
      rd("ctrl_rb", 32'h08, 32'h1);

      // Counter carry: preload just below a 32-bit carry
      force dut.cnt_q = 64'h0000_0000_FFFF_FFF0;
      #1 release dut.cnt_q;
      repeat (15) @(posedge CLK);
      #1;
      rd("cnt_lo_pre", 32'h14, 32'hFFFF_FFFF);
      rd("cnt_hi_pre", 32'h18, 32'h0);
      rd("cnt_lo_post", 32'h14, 32'h1);
      rd("cnt_hi_post", 32'h18, 32'h1);

      // User control word 2, then async reset mid-read
      wr(32'h28, 32'hCAFE_0002);
      chk("uctrl2", uctrl_o[95:64], 32'hCAFE_0002);
      chk("uctrl1", uctrl_o[63:32], 32'h0);
      rd("uctrl2_rb", 32'h28, 32'hCAFE_0002);
      RADR = 32'h0; RDEN = 1'b1;
      @(posedge CLK); #1;
      RDEN = 1'b0;
      chk("pre_rst_vld", 32'(RVLD), 32'd1);
      #1 RST = 1'b1;
      #1;
      chk("rst_mid_vld", 32'(RVLD), 32'd0);
      chk("rst_mid_uctrl", uctrl_o[95:64], 32'h0);
      RDEN = 1'b1;
      @(posedge CLK); #1;
      RDEN = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rst_read_novld", 32'(RVLD), 32'd0);
      @(posedge CLK); #1;
      chk("rst_read_novld2", 32'(RVLD), 32'd0);
      rd("post_rst_scratch", 32'h04, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
